// File: rtl/timebase_counter_if.sv
// Interface bundle between the time-base block and its core-side neighbours
// (oscillator input, freeze controls, SPR write port, register/strobe outputs).
interface timebase_counter_if #(
    parameter int unsigned HALF_W = 32
);
    logic              oscTimer;
    logic              DBG_freezeTimers;
    logic              JTG_freezeTimers;
    logic              PCL_mtSPR;
    logic              PCL_sprHold;
    logic              tblDcd;
    logic              tbuDcd;
    logic [0:HALF_W-1] sprWrData;
    logic [0:HALF_W-1] tblL2;
    logic [0:HALF_W-1] tbuL2;
    logic              timerTic;
    logic              freezeTimersNEG;
    logic              segCarry;
    logic              tblCarry;

    modport master (
        output oscTimer, DBG_freezeTimers, JTG_freezeTimers, PCL_mtSPR, PCL_sprHold,
               tblDcd, tbuDcd, sprWrData,
        input  tblL2, tbuL2, timerTic, freezeTimersNEG, segCarry, tblCarry
    );

    modport slave (
        input  oscTimer, DBG_freezeTimers, JTG_freezeTimers, PCL_mtSPR, PCL_sprHold,
               tblDcd, tbuDcd, sprWrData,
        output tblL2, tbuL2, timerTic, freezeTimersNEG, segCarry, tblCarry
    );
endinterface

// File: rtl/timebase_counter.sv
// Time-base register pair (TBL/TBU): tick derivation, split-segment increment,
// TBU carry, debug/JTAG freeze and mtSPR writes. Bit 0 is the MSB throughout.
module timebase_counter #(
    parameter int unsigned HALF_W    = 32,
    parameter int unsigned SEG_W     = 8,
    parameter bit          TICK_SYNC = 1'b1
) (
    input logic                CB,
    input logic                reset,
    timebase_counter_if.slave  bus
);
    localparam int unsigned UpW = HALF_W - SEG_W;
    localparam logic [0:SEG_W-1]  SegOne  = SEG_W'(1);
    localparam logic [0:UpW-1]    UpOne   = UpW'(1);
    localparam logic [0:HALF_W-1] HalfOne = HALF_W'(1);

    logic [0:HALF_W-1] tblQ, tblD;
    logic [0:HALF_W-1] tbuQ, tbuD;
    logic timerTic;
    logic freezeNeg;
    logic inc;
    logic wrTbl;
    logic wrTbu;
    logic segCarry;
    logic tblCarry;

    if (TICK_SYNC) begin : gSync
        logic sync1Q, sync2Q, prevQ;
        always_ff @(posedge CB) begin
            if (reset) begin
                sync1Q <= 1'b0;
                sync2Q <= 1'b0;
                prevQ  <= 1'b0;
            end else begin
                sync1Q <= bus.oscTimer;
                sync2Q <= sync1Q;
                prevQ  <= sync2Q;
            end
        end
        assign timerTic = sync2Q & ~prevQ;
    end else begin : gDirect
        assign timerTic = bus.oscTimer;
    end

    always_comb begin
        freezeNeg = ~(bus.DBG_freezeTimers | bus.JTG_freezeTimers);
        inc       = timerTic & freezeNeg;
        wrTbl     = bus.PCL_mtSPR & bus.tblDcd & ~bus.PCL_sprHold;
        wrTbu     = bus.PCL_mtSPR & bus.tbuDcd & ~bus.PCL_sprHold;
        segCarry  = (&tblQ[UpW:HALF_W-1]) & inc;
        tblCarry  = (&tblQ) & inc;

        tblD = tblQ;
        if (wrTbl) begin
            tblD = bus.sprWrData;
        end else if (inc) begin
            // Low segment counts every tick; upper part only on its carry.
            tblD[UpW:HALF_W-1] = tblQ[UpW:HALF_W-1] + SegOne;
            if (segCarry) begin
                tblD[0:UpW-1] = tblQ[0:UpW-1] + UpOne;
            end
        end

        tbuD = tbuQ;
        if (wrTbu) begin
            tbuD = bus.sprWrData;
        end else if (tblCarry && !wrTbl) begin
            tbuD = tbuQ + HalfOne;
        end
    end

    always_ff @(posedge CB) begin
        if (reset) begin
            tblQ <= '0;
            tbuQ <= '0;
        end else begin
            tblQ <= tblD;
            tbuQ <= tbuD;
        end
    end

    assign bus.tblL2           = tblQ;
    assign bus.tbuL2           = tbuQ;
    assign bus.timerTic        = timerTic;
    assign bus.freezeTimersNEG = freezeNeg;
    assign bus.segCarry        = segCarry;
    assign bus.tblCarry        = tblCarry;

    aDcdExclusive: assert property (@(posedge CB) disable iff (reset)
        !(bus.tblDcd && bus.tbuDcd));
endmodule

// File: tb/tb_timebase_counter.sv
// Directed bench for timebase_counter (TICK_SYNC=1, 32-bit halves, 8-bit low segment).
module tb_timebase_counter;
    logic CB = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic ticSeen, segSeen, tblcSeen;

    timebase_counter_if #(.HALF_W(32)) bus ();

    timebase_counter #(
        .HALF_W   (32),
        .SEG_W    (8),
        .TICK_SYNC(1'b1)
    ) dut (
        .CB   (CB),
        .reset(reset),
        .bus  (bus)
    );

    always #5 CB = ~CB;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CB);
            #1;
        end
    endtask

    task automatic clearSpr();
        bus.PCL_mtSPR   = 1'b0;
        bus.PCL_sprHold = 1'b0;
        bus.tblDcd      = 1'b0;
        bus.tbuDcd      = 1'b0;
        bus.sprWrData   = '0;
    endtask

    task automatic sprWrite(input bit toTbu, input logic [0:31] data);
        bus.PCL_mtSPR = 1'b1;
        bus.tblDcd    = !toTbu;
        bus.tbuDcd    = toTbu;
        bus.sprWrData = data;
        idle(1);
        clearSpr();
    endtask

    // One oscillator pulse; the optional SPR access is placed in the tick cycle.
    task automatic tick(input bit wl, input bit wu, input bit hold, input logic [0:31] data);
        bus.oscTimer = 1'b1;
        idle(2);
        bus.PCL_mtSPR   = wl | wu;
        bus.tblDcd      = wl;
        bus.tbuDcd      = wu;
        bus.PCL_sprHold = hold;
        bus.sprWrData   = data;
        @(negedge CB);
        ticSeen  = bus.timerTic;
        segSeen  = bus.segCarry;
        tblcSeen = bus.tblCarry;
        @(posedge CB);
        #1;
        clearSpr();
        bus.oscTimer = 1'b0;
        idle(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.oscTimer = 1'b1;
        bus.PCL_mtSPR = 1'b1; bus.tblDcd = 1'b1; bus.sprWrData = 32'hDEADBEEF;
        idle(3);
        vectors++;
        if (bus.tblL2 !== 32'h0) begin
            miscompares++; $display("FAIL reset_write_inflight: tbl=%h want %h", bus.tblL2, 32'h0);
        end
        clearSpr();
        bus.oscTimer = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(3);
        @(negedge CB);
        vectors++;
        if (bus.tblL2 !== 32'h0) begin
            miscompares++; $display("FAIL reset_tbl: got %h want %h", bus.tblL2, 32'h0);
        end
        vectors++;
        if (bus.tbuL2 !== 32'h0) begin
            miscompares++; $display("FAIL reset_tbu: got %h want %h", bus.tbuL2, 32'h0);
        end
        vectors++;
        if ({bus.timerTic, bus.segCarry, bus.tblCarry} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 000",
                     {bus.timerTic, bus.segCarry, bus.tblCarry});
        end
        vectors++;
        if (bus.freezeTimersNEG !== 1'b1) begin
            miscompares++; $display("FAIL reset_freezeneg: got %b want 1", bus.freezeTimersNEG);
        end
        @(posedge CB); #1;
    endtask

    task automatic test_level_hold();
        int count = 0;
        int at = -1;
        bus.oscTimer = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CB);
            if (bus.timerTic === 1'b1) begin
                count++;
                at = i;
            end
            @(posedge CB); #1;
        end
        bus.oscTimer = 1'b0;
        idle(3);
        vectors++;
        if (count !== 1) begin
            miscompares++; $display("FAIL level_tick_count: got %0d want 1", count);
        end
        vectors++;
        if (at !== 2) begin
            miscompares++; $display("FAIL level_tick_latency: got %0d want 2", at);
        end
        vectors++;
        if (bus.tblL2 !== 32'h00000001) begin
            miscompares++; $display("FAIL level_tbl: got %h want %h", bus.tblL2, 32'h1);
        end
    endtask

    task automatic test_seg_carry();
        sprWrite(1'b0, 32'h000000FF);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({ticSeen, segSeen, tblcSeen} !== 3'b110) begin
            miscompares++;
            $display("FAIL seg_strobes: got %b want 110", {ticSeen, segSeen, tblcSeen});
        end
        vectors++;
        if (bus.tblL2 !== 32'h00000100) begin
            miscompares++; $display("FAIL seg_tbl: got %h want %h", bus.tblL2, 32'h100);
        end
    endtask

    task automatic test_full_wrap();
        sprWrite(1'b0, 32'hFFFFFFFF);
        sprWrite(1'b1, 32'h00000007);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({segSeen, tblcSeen} !== 2'b11) begin
            miscompares++; $display("FAIL wrap_strobes: got %b want 11", {segSeen, tblcSeen});
        end
        vectors++;
        if (bus.tblL2 !== 32'h0 || bus.tbuL2 !== 32'h00000008) begin
            miscompares++;
            $display("FAIL wrap_regs: got %h_%h want %h_%h", bus.tbuL2, bus.tblL2, 32'h8, 32'h0);
        end
    endtask

    task automatic test_tbu_wrap();
        sprWrite(1'b1, 32'hFFFFFFFF);
        sprWrite(1'b0, 32'hFFFFFFFF);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (bus.tblL2 !== 32'h0 || bus.tbuL2 !== 32'h0) begin
            miscompares++;
            $display("FAIL tbu_wrap: got %h_%h want %h_%h", bus.tbuL2, bus.tblL2, 32'h0, 32'h0);
        end
    endtask

    task automatic test_freeze();
        sprWrite(1'b0, 32'h000000FF);
        bus.DBG_freezeTimers = 1'b1;
        #1;
        vectors++;
        if (bus.freezeTimersNEG !== 1'b0) begin
            miscompares++; $display("FAIL freeze_dbg_neg: got %b want 0", bus.freezeTimersNEG);
        end
        for (int i = 0; i < 5; i++) begin
            tick(i == 2, 1'b0, 1'b0, 32'h12345678);
            vectors++;
            if ({ticSeen, segSeen, tblcSeen} !== 3'b100) begin
                miscompares++;
                $display("FAIL freeze_strobes[%0d]: got %b want 100", i,
                         {ticSeen, segSeen, tblcSeen});
            end
        end
        vectors++;
        if (bus.tblL2 !== 32'h12345678) begin
            miscompares++; $display("FAIL freeze_tbl: got %h want %h", bus.tblL2, 32'h12345678);
        end
        bus.DBG_freezeTimers = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (bus.tblL2 !== 32'h12345679) begin
            miscompares++; $display("FAIL unfreeze_tbl: got %h want %h", bus.tblL2, 32'h12345679);
        end
        bus.JTG_freezeTimers = 1'b1;
        #1;
        vectors++;
        if (bus.freezeTimersNEG !== 1'b0) begin
            miscompares++; $display("FAIL freeze_jtg_neg: got %b want 0", bus.freezeTimersNEG);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (bus.tblL2 !== 32'h12345679) begin
            miscompares++; $display("FAIL jtg_freeze_tbl: got %h want %h", bus.tblL2, 32'h12345679);
        end
        bus.JTG_freezeTimers = 1'b0;
    endtask

    task automatic test_collisions();
        sprWrite(1'b0, 32'hFFFFFFFF);
        sprWrite(1'b1, 32'h00000003);
        tick(1'b1, 1'b0, 1'b0, 32'hAAAA0000);
        vectors++;
        if (tblcSeen !== 1'b1) begin
            miscompares++; $display("FAIL coll_wrtbl_carry: got %b want 1", tblcSeen);
        end
        vectors++;
        if (bus.tblL2 !== 32'hAAAA0000 || bus.tbuL2 !== 32'h00000003) begin
            miscompares++;
            $display("FAIL coll_wrtbl: got %h_%h want %h_%h", bus.tbuL2, bus.tblL2,
                     32'h3, 32'hAAAA0000);
        end
        sprWrite(1'b0, 32'hFFFFFFFF);
        tick(1'b1, 1'b0, 1'b1, 32'hAAAA0000);
        vectors++;
        if (bus.tblL2 !== 32'h0 || bus.tbuL2 !== 32'h00000004) begin
            miscompares++;
            $display("FAIL coll_hold: got %h_%h want %h_%h", bus.tbuL2, bus.tblL2, 32'h4, 32'h0);
        end
        sprWrite(1'b0, 32'hFFFFFFFF);
        tick(1'b0, 1'b1, 1'b0, 32'h00000005);
        vectors++;
        if (bus.tblL2 !== 32'h0 || bus.tbuL2 !== 32'h00000005) begin
            miscompares++;
            $display("FAIL coll_wrtbu: got %h_%h want %h_%h", bus.tbuL2, bus.tblL2, 32'h5, 32'h0);
        end
    endtask

    task automatic test_spr_gating();
        bus.PCL_mtSPR = 1'b1; bus.PCL_sprHold = 1'b1; bus.tblDcd = 1'b1;
        bus.sprWrData = 32'h11111111;
        idle(1);
        clearSpr();
        bus.tbuDcd = 1'b1; bus.sprWrData = 32'h00000009;
        idle(1);
        clearSpr();
        vectors++;
        if (bus.tblL2 !== 32'h0 || bus.tbuL2 !== 32'h00000005) begin
            miscompares++;
            $display("FAIL spr_gating: got %h_%h want %h_%h", bus.tbuL2, bus.tblL2, 32'h5, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.oscTimer = 1'b0;
        bus.DBG_freezeTimers = 1'b0;
        bus.JTG_freezeTimers = 1'b0;
        clearSpr();
        idle(1);
        test_reset();
        test_level_hold();
        test_seg_carry();
        test_full_wrap();
        test_tbu_wrap();
        test_freeze();
        test_collisions();
        test_spr_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
